clk_glitcher: RTL and testbench

CLK_GLITCHER -- requirements
Module: clk_glitcher

---
 rtl/glitch_pkg.sv | 18 +
 rtl/sync_edge.sv | 29 ++
 rtl/clk_glitcher.sv | 150 +++++++++++++++
 tb/tb_clk_glitcher.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// Shared types and default widths for the clock glitcher.
// Latency: n/a (types only).
// Backpressure: n/a.
package glitch_pkg;

    localparam int DEF_DELAY_W = 16;
    localparam int DEF_WIDTH_W = 4;
    localparam int REPEAT_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_DELAY  = 3'd2,
        ST_GLITCH = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Latency: rise_o is high for one cycle, two clk edges after the input rises.
// Backpressure: none; every qualifying edge produces exactly one pulse.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/clk_glitcher.sv
// Target-clock glitcher: inverts clk_target for width clk cycles, delay target edges after a trigger.
// Latency: clk_target_o is clk_target_i ^ glitch, one clk late. Optional GLITCH_REPEAT_EN adds repeat_i.
// Backpressure: none; arm_i is dropped unless idle, triggers are dropped unless armed.
module clk_glitcher
    import glitch_pkg::*;
#(
    parameter int DELAY_W = DEF_DELAY_W,
    parameter int WIDTH_W = DEF_WIDTH_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_target_i,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic               trig_i,
    input  logic [DELAY_W-1:0] delay_i,
    input  logic [WIDTH_W-1:0] width_i,
`ifdef GLITCH_REPEAT_EN
    input  logic [REPEAT_W-1:0] repeat_i,
`endif
    output logic               clk_target_o,
    output logic               busy_o,
    output logic               done_o
);

    state_e             state_q, state_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [WIDTH_W-1:0] wcnt_q, wcnt_d;
`ifdef GLITCH_REPEAT_EN
    logic [REPEAT_W-1:0] rep_q, rep_d;
`endif
    logic               tgt_prev_q;
    logic               clk_tgt_q;
    logic               trig_rise;
    logic               tgt_edge;
    logic               glitch_active;

    sync_edge u_trig_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (trig_i),
        .rise_o  (trig_rise)
    );

    assign tgt_edge      = clk_target_i & ~tgt_prev_q;
    assign glitch_active = (state_q == ST_GLITCH);

    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        width_d = width_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
`ifdef GLITCH_REPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    state_d = ST_ARMED;
                    delay_d = delay_i;
                    width_d = width_i;
`ifdef GLITCH_REPEAT_EN
                    rep_d   = repeat_i;
`endif
                end
            end
            ST_ARMED: begin
                if (trig_rise) begin
                    state_d = ST_DELAY;
                    cnt_d   = delay_q;
                end
            end
            ST_DELAY: begin
                // The zero test uses the registered count, so the glitch starts
                // one cycle after the last counted edge (or after the trigger).
                if (cnt_q == '0) begin
                    if (width_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_GLITCH;
                        wcnt_d  = width_q;
                    end
                end else if (tgt_edge) begin
                    cnt_d = cnt_q - DELAY_W'(1);
                end
            end
            ST_GLITCH: begin
                if (wcnt_q <= WIDTH_W'(1)) begin
                    wcnt_d  = '0;
                    state_d = ST_DONE;
`ifdef GLITCH_REPEAT_EN
                    if (rep_q != '0) begin
                        rep_d   = rep_q - REPEAT_W'(1);
                        state_d = ST_DELAY;
                        cnt_d   = delay_q;
                    end
`endif
                end else begin
                    wcnt_d = wcnt_q - WIDTH_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            wcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            delay_q    <= '0;
            width_q    <= '0;
            cnt_q      <= '0;
            wcnt_q     <= '0;
`ifdef GLITCH_REPEAT_EN
            rep_q      <= '0;
`endif
            tgt_prev_q <= 1'b0;
            clk_tgt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            width_q    <= width_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
`ifdef GLITCH_REPEAT_EN
            rep_q      <= rep_d;
`endif
            tgt_prev_q <= clk_target_i;
            clk_tgt_q  <= clk_target_i ^ glitch_active;
        end
    end

    assign clk_target_o = clk_tgt_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_clk_glitcher.sv
// Randomised and directed bench for clk_glitcher with a timestamp-based reference model.
module tb_clk_glitcher;

`ifdef GLITCH_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_target_i = 1'b0;
    logic        arm_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        trig_i = 1'b0;
    logic [15:0] delay_i = '0;
    logic [3:0]  width_i = '0;
    logic [3:0]  rep_sel = '0;
    logic        clk_target_o;
    logic        busy_o;
    logic        done_o;

    clk_glitcher #(.DELAY_W(16), .WIDTH_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_target_i (clk_target_i),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .trig_i       (trig_i),
        .delay_i      (delay_i),
        .width_i      (width_i),
`ifdef GLITCH_REPEAT_EN
        .repeat_i     (rep_sel),
`endif
        .clk_target_o (clk_target_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    // Divided target clock: period div clk cycles, roughly half high.
    int div = 3;
    int ph  = 0;
    initial forever begin
        @(posedge clk);
        #3;
        ph = (ph + 1 >= div) ? 0 : ph + 1;
        clk_target_i = (ph < (div + 1) / 2);
    end

    // Reference model: times every glitch window by counting target edges.
    int cyc = 0;
    bit m_armed, m_run, m_fin;
    int mD, mW, mR, m_left, m_gs;
    bit t1, t2, t3, tp, g_prev, g_now;
    bit e_out, e_busy, e_done;

    initial forever begin
        bit rise, tedge, done_now;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            m_armed = 0; m_run = 0; m_fin = 0; m_gs = -1; m_left = 0;
            t1 = 0; t2 = 0; t3 = 0; tp = 0; g_prev = 0; g_now = 0;
            e_out = 0; e_busy = 0; e_done = 0;
        end else begin
            rise  = t2 & ~t3;
            t3 = t2; t2 = t1; t1 = trig_i;
            tedge = clk_target_i & ~tp;
            tp = clk_target_i;
            g_prev = g_now;
            done_now = 0;
            if (abort_i) begin
                m_armed = 0; m_run = 0;
            end else if (m_fin) begin
                // completion cycle: the block is about to go idle and ignores inputs
            end else if (!m_armed && !m_run) begin
                if (arm_i) begin
                    m_armed = 1; mD = int'(delay_i); mW = int'(width_i);
                    mR = REP_ON ? int'(rep_sel) : 0;
                end
            end else if (m_armed) begin
                if (rise) begin
                    m_armed = 0; m_run = 1; m_left = mD;
                    m_gs = (mD == 0) ? cyc + 1 : -1;
                end
            end else if (m_run) begin
                if (m_gs < 0) begin
                    if (tedge && m_left > 0) begin
                        m_left--;
                        if (m_left == 0) m_gs = cyc + 1;
                    end
                end else if (cyc == m_gs + mW) begin
                    if (mW > 0 && mR > 0) begin
                        mR--; m_left = mD;
                        m_gs = (mD == 0) ? cyc + 1 : -1;
                    end else begin
                        m_run = 0; done_now = 1;
                    end
                end
            end
            m_fin  = done_now;
            g_now  = m_run && m_gs >= 0 && cyc >= m_gs && cyc < m_gs + mW;
            e_out  = clk_target_i ^ g_prev;
            e_busy = m_armed || m_run || done_now;
            e_done = done_now;
        end
    end

    // Per-cycle comparison plus observation counters for the directed checks.
    int n_inv = 0, n_done = 0, first_inv = -1, done_cyc = -1, fall_cyc = -1;
    logic busy_last = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        chk("clk_target_o", clk_target_o, e_out);
        chk("busy_o", busy_o, e_busy);
        chk("done_o", done_o, e_done);
        if (rst && clk_target_o !== clk_target_i) begin
            n_inv++;
            if (first_inv < 0) first_inv = cyc;
        end
        if (done_o === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        if (busy_last === 1'b1 && busy_o === 1'b0) fall_cyc = cyc;
        busy_last = busy_o;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic clr();
        n_inv = 0; n_done = 0; first_inv = -1; done_cyc = -1; fall_cyc = -1;
    endtask

    task automatic do_arm(input int d, input int w, input int r);
        delay_i = 16'(d); width_i = 4'(w); rep_sel = 4'(r); arm_i = 1'b1;
        step(1);
        arm_i = 1'b0;
        delay_i = 16'($urandom); width_i = 4'($urandom); rep_sel = 4'($urandom);
    endtask

    int trig_k;
    task automatic trigger(input int hold);
        trig_i = 1'b1;
        trig_k = cyc + 1;
        step(hold);
        trig_i = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (busy_o === 1'b0) break;
            step(1);
        end
        chk("wait_idle_timeout", busy_o, 0);
    endtask

    initial begin
        step(3);
        chk("rst_clk_target_o", clk_target_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        rst = 1'b1;
        step(2);

        // delay 5, width 2 on a clk/3 target
        clr(); do_arm(5, 2, 0); step(4); trigger(3); wait_idle(300); step(2);
        chk("A_inverted_cycles", n_inv, 2);
        chk("A_done_pulses", n_done, 1);

        // delay 0, width 1: first inverted output 4 edges after trigger is sampled
        clr(); do_arm(0, 1, 0); step(3); trigger(3); wait_idle(300); step(2);
        chk("B_latency", first_inv - trig_k, 4);
        chk("B_inverted_cycles", n_inv, 1);
        chk("B_busy_fall_after_done", fall_cyc - done_cyc, 1);

        // width 0: output stays clean, done still pulses
        clr(); do_arm(4, 0, 0); step(2); trigger(2); wait_idle(300); step(2);
        chk("C_inverted_cycles", n_inv, 0);
        chk("C_done_pulses", n_done, 1);

        // abort in a long delay, then re-arm
        clr(); do_arm(100, 3, 0); trigger(3); step(10);
        abort_i = 1'b1; step(1); abort_i = 1'b0;
        chk("D_busy_after_abort", busy_o, 0);
        step(20);
        chk("D_inverted_cycles", n_inv, 0);
        chk("D_done_pulses", n_done, 0);
        clr(); do_arm(2, 3, 0); step(2); trigger(2); wait_idle(300); step(2);
        chk("D_rearm_inverted", n_inv, 3);
        chk("D_rearm_done", n_done, 1);

        // trigger already high at arm; arm pulse while armed is ignored
        clr(); trig_i = 1'b1; step(5); do_arm(1, 2, 0); step(30);
        do_arm(7, 5, 0); step(5);
        chk("E_still_armed", busy_o, 1);
        chk("E_no_glitch_yet", n_inv, 0);
        trig_i = 1'b0; step(2); trigger(2); wait_idle(300); step(2);
        chk("E_inverted_cycles", n_inv, 2);

        // reset in the middle of a 15-cycle glitch
        clr(); do_arm(1, 15, 0); trigger(2);
        for (int i = 0; i < 100 && n_inv < 3; i++) step(1);
        chk("F_glitch_started", (n_inv >= 3), 1);
        rst = 1'b0;
        #1;
        chk("F_async_clk_target_o", clk_target_o, 0);
        chk("F_async_busy", busy_o, 0);
        step(3); rst = 1'b1; step(2);
        clr(); step(20);
        chk("F_clean_after_release", n_inv, 0);
        chk("F_idle_after_release", busy_o, 0);

`ifdef GLITCH_REPEAT_EN
        clr(); do_arm(3, 1, 2); step(2); trigger(2); wait_idle(400); step(2);
        chk("G_repeat_inverted", n_inv, 3);
        chk("G_repeat_done", n_done, 1);
`endif

        // randomised sequences; the per-cycle model comparison does the checking
        for (int it = 0; it < 40; it++) begin
            div = $urandom_range(2, 4);
            do_arm($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 2));
            step($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) do_arm($urandom_range(0, 6), $urandom_range(0, 4), 0);
            trigger($urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) begin
                step($urandom_range(0, 10));
                abort_i = 1'b1; step(1); abort_i = 1'b0;
            end
            wait_idle(500);
            step($urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
